// File: rtl/lum_conv_sched.sv
// lum_conv_sched: round-robin scheduler that shares one lum_conv luminance
// converter between CH_NUM requesters. One request is accepted at a time. Its
// exponent/mantissa is held on the converter inputs for MULT_LATENCY cycles.
// The result is then captured into that channel's level register and the
// channel's update strobe is pulsed.
//
// Optional feature (macro LUM_CONV_SCHED_CACHE_EN): each channel remembers the
// last {lum_e, lum_m} it converted. A repeated request is answered without a
// conversion: lum_update pulses and lum_level stays as it is.
//
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   req_valid[CH_NUM]        per-channel request valid
//   req_lum_e[4*CH_NUM]      per-channel exponent, channel k at [4k+3:4k]
//   req_lum_m[8*CH_NUM]      per-channel mantissa, channel k at [8k+7:8k]
//   req_ready[CH_NUM]        combinational accept strobe, one-hot or zero
//   conv_en                  converter clock enable, 1 outside reset
//   conv_lum_e/conv_lum_m    operands presented to the converter
//   conv_lum_out             converter result
//   lum_level[5*CH_NUM]      per-channel level, channel k at [5k+4:5k]
//   lum_update[CH_NUM]       one-cycle pulse when a channel level is written
//   busy                     high while a conversion is in flight

module lum_conv_sched #(
   parameter int unsigned CH_NUM       = 4,
   parameter int unsigned MULT_LATENCY = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [CH_NUM-1:0]     req_valid,
   input  logic [4*CH_NUM-1:0]   req_lum_e,
   input  logic [8*CH_NUM-1:0]   req_lum_m,
   output logic [CH_NUM-1:0]     req_ready,
   output logic                  conv_en,
   output logic [3:0]            conv_lum_e,
   output logic [7:0]            conv_lum_m,
   input  logic [4:0]            conv_lum_out,
   output logic [5*CH_NUM-1:0]   lum_level,
   output logic [CH_NUM-1:0]     lum_update,
   output logic                  busy
);

   localparam int unsigned PTR_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int unsigned CNT_W = $clog2(MULT_LATENCY + 1);

   typedef enum logic [1:0] {
      st_idle    = 2'd0,
      st_wait    = 2'd1,
      st_capture = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_nxt;
   logic [PTR_W-1:0]   ptr_q;
   logic [PTR_W-1:0]   tag_q;
   logic [PTR_W-1:0]   gnt_idx;
   logic [PTR_W-1:0]   scan_idx;
   logic [CNT_W-1:0]   cnt_q;
   logic               gnt_found;
   logic               xfer;
   logic               cache_hit;
   logic [3:0]         sel_e;
   logic [7:0]         sel_m;

   // First valid channel at or above the pointer, wrapping at CH_NUM-1.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      scan_idx  = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         if (32'(ptr_q) + i >= CH_NUM)
            scan_idx = PTR_W'(32'(ptr_q) + i - CH_NUM);
         else
            scan_idx = PTR_W'(32'(ptr_q) + i);
         if (!gnt_found && req_valid[scan_idx]) begin
            gnt_found = 1'b1;
            gnt_idx   = scan_idx;
         end
      end
   end

   assign sel_e     = req_lum_e[4*gnt_idx +: 4];
   assign sel_m     = req_lum_m[8*gnt_idx +: 8];
   assign xfer      = (state_q == st_idle) && gnt_found;
   assign req_ready = xfer ? (CH_NUM'(1) << gnt_idx) : '0;

`ifdef LUM_CONV_SCHED_CACHE_EN
   logic [CH_NUM-1:0] cache_vld_q;
   logic [3:0]        cache_e_q [CH_NUM];
   logic [7:0]        cache_m_q [CH_NUM];

   assign cache_hit = cache_vld_q[gnt_idx] &&
                      (cache_e_q[gnt_idx] == sel_e) &&
                      (cache_m_q[gnt_idx] == sel_m);

   // Cache holds the operands of the last completed conversion per channel.
   always_ff @(posedge clock) begin
      if (reset) begin
         cache_vld_q <= '0;
         for (int unsigned k = 0; k < CH_NUM; k++) begin
            cache_e_q[k] <= '0;
            cache_m_q[k] <= '0;
         end
      end else if (state_q == st_capture) begin
         cache_vld_q[tag_q] <= 1'b1;
         cache_e_q[tag_q]   <= conv_lum_e;
         cache_m_q[tag_q]   <= conv_lum_m;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   // State register; busy is registered alongside it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= st_idle;
         busy    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         busy    <= (state_nxt != st_idle);
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         st_idle:    if (xfer && !cache_hit) state_nxt = st_wait;
         st_wait:    if (cnt_q == CNT_W'(1)) state_nxt = st_capture;
         st_capture: state_nxt = st_idle;
         default:    state_nxt = st_idle;
      endcase
   end

   // Datapath: operand hold, latency counter, result capture and strobes.
   always_ff @(posedge clock) begin
      if (reset) begin
         conv_en    <= 1'b0;
         ptr_q      <= '0;
         tag_q      <= '0;
         cnt_q      <= '0;
         conv_lum_e <= '0;
         conv_lum_m <= '0;
         lum_level  <= '0;
         lum_update <= '0;
      end else begin
         conv_en    <= 1'b1;
         lum_update <= '0;
         if (xfer) begin
            ptr_q <= (gnt_idx == PTR_W'(CH_NUM - 1)) ? '0 : gnt_idx + PTR_W'(1);
            if (cache_hit) begin
               lum_update[gnt_idx] <= 1'b1;
            end else begin
               conv_lum_e <= sel_e;
               conv_lum_m <= sel_m;
               tag_q      <= gnt_idx;
               cnt_q      <= CNT_W'(MULT_LATENCY);
            end
         end
         if (state_q == st_wait)
            cnt_q <= cnt_q - CNT_W'(1);
         // Result is stored unmodified; saturation is the converter's job.
         if (state_q == st_capture) begin
            lum_level[5*tag_q +: 5] <= conv_lum_out;
            lum_update[tag_q]       <= 1'b1;
         end
      end
   end

endmodule

// File: doc/lum_conv_sched.md
Name: lum_conv_sched

Overview:
- Round-robin scheduler that time-shares one lum_conv luminance converter between CH_NUM requesters, such as backlight or indicator channels.
- Accepts exponent/mantissa requests through per-channel valid/ready handshakes.
- Presents each accepted request to the converter and holds it stable for the full converter latency. lum_conv saturates combinationally on its current lum_e, so the inputs must not change before capture.
- Captures the 5-bit result into a per-channel level register and pulses that channel's update strobe.

Parameters:
- CH_NUM, 4: number of requesting channels, range 2..16.
- MULT_LATENCY, 1: converter pipeline depth in clocks, range 1..4.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  CH_NUM  per-channel request valid
- req_lum_e  in  4*CH_NUM  per-channel exponent; channel k at bits [4k+3:4k]
- req_lum_m  in  8*CH_NUM  per-channel mantissa; channel k at bits [8k+7:8k]
- req_ready  out  CH_NUM  per-channel accept strobe, one-hot or zero
- conv_en  out  1  converter clock enable
- conv_lum_e  out  4  exponent to converter
- conv_lum_m  out  8  mantissa to converter
- conv_lum_out  in  5  converter result
- lum_level  out  5*CH_NUM  per-channel converted level; channel k at bits [5k+4:5k]
- lum_update  out  CH_NUM  one-cycle pulse when a channel's lum_level changes value or is rewritten
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset values: all outputs 0 (conv_en=0, req_ready=0, conv_lum_e=0, conv_lum_m=0, lum_level=0, lum_update=0, busy=0). FSM=IDLE, round-robin pointer=0, wait counter=0.
- Outside reset, conv_en is 1 every cycle.
- FSM states:
  - IDLE: if any req_valid is set, grant the first set channel searching upward from the pointer, wrapping at CH_NUM-1 to 0.
  - req_ready[g] is combinational, high only in IDLE, and only for the granted channel.
  - Transfer happens on req_valid[g] & req_ready[g].
  - On transfer: register conv_lum_e/conv_lum_m from channel g, store tag g, set pointer=(g+1) mod CH_NUM, load counter=MULT_LATENCY, go to WAIT.
  - WAIT: decrement counter each cycle; when it reaches 1, go to CAPTURE. conv_lum_e/m are held stable throughout.
  - CAPTURE: sample conv_lum_out into lum_level[tag], go to IDLE. conv_lum_e/m are still held.
- lum_level[tag] and lum_update[tag]=1 appear in the cycle after CAPTURE, which is also the first IDLE cycle.
- Timing, with acceptance in cycle 0:
  - Converter inputs valid from cycle 1.
  - CAPTURE in cycle 1+MULT_LATENCY.
  - lum_update in cycle 2+MULT_LATENCY.
  - Next accept is possible in that same cycle.
  - Throughput is one conversion per MULT_LATENCY+2 cycles.
- Requester rules: keep req_valid and data stable until req_ready. Deasserting before the grant is legal and no conversion occurs. Data changes after acceptance do not affect the conversion in flight.
- Simultaneous requests: served strictly round-robin. With all channels continuously valid, each channel is granted exactly once per CH_NUM grants.
- No arithmetic in this block: conv_lum_out is stored unmodified, and 5'b11111 saturation comes from the converter.
- Reset mid-operation: the in-flight conversion is discarded with no lum_update pulse, all lum_level values clear to 0, and the FSM returns to IDLE.
- lum_update pulses even when the new level equals the old one.

Optional Feature:
- Macro: LUM_CONV_SCHED_CACHE_EN
- Defined:
  - Each channel keeps its last converted {lum_e, lum_m} and a cache-valid bit, cleared on reset.
  - In IDLE, a granted request matching the channel's cache is accepted (req_ready=1) without touching the converter. lum_update pulses next cycle, lum_level is unchanged, and the FSM stays IDLE with the pointer advanced.
  - The cache is written at CAPTURE.
- Undefined: every accepted request runs a full conversion; no cache storage is generated.

Test Plan:
- Real lum_conv behind conv_en, MULT_LATENCY=1. Channel 0 requests e=3, m=0x80 at cycle 0 → req_ready[0] in cycle 0, lum_level[0]=4 with lum_update[0] in cycle 3, busy high in cycles 1-2.
- Channels 0-3 all valid continuously, with (e,m) = (4,0xFF), (15,0x00), (0,0x10), (5,0xFF) → grant order 0,1,2,3,0... → levels 15, 31, 0, 31; grants spaced exactly 3 cycles apart.
- Pointer at 2, only channels 0 and 3 valid → channel 3 granted first, then channel 0.
- Reset asserted in the WAIT cycle of a channel 1 conversion → no lum_update[1], all lum_level=0, next request after reset granted to channel 0.
- Channel 2 changes req_lum_e from 4 to 15 one cycle after acceptance → captured level reflects e=4 and conv_lum_e stays at 4 through CAPTURE.
- With LUM_CONV_SCHED_CACHE_EN: channel 1 repeats e=4, m=0xFF → second request gives lum_update[1] one cycle after acceptance, busy stays 0. Without the macro the same stimulus takes 3 cycles and busy goes high.
